// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed 4-digit BCD display path.
package disp_pkg;

   localparam logic [2:0] AN_D0      = 3'b000;
   localparam logic [2:0] AN_D1      = 3'b010;
   localparam logic [2:0] AN_D2      = 3'b100;
   localparam logic [2:0] AN_D3      = 3'b110;
   localparam logic [3:0] BLANK_CODE = 4'hF;

   typedef enum logic [1:0] {
      A_IDLE,
      B_ACTIVE,
      A_COOLDOWN
   } arb_state_t;

   // Encoded digit select for a slot index.
   function automatic logic [2:0] an_code(input logic [1:0] idx);
      case (idx)
         2'd0:    return AN_D0;
         2'd1:    return AN_D1;
         2'd2:    return AN_D2;
         default: return AN_D3;
      endcase
   endfunction

   // Extract one BCD digit from a packed 4-digit word.
   function automatic logic [3:0] digit_of(input logic [15:0] data, input logic [1:0] idx);
      return data[{idx, 2'b00} +: 4];
   endfunction

   // Replace every masked digit with the blank code.
   function automatic logic [15:0] blank_mask(input logic [15:0] data, input logic [3:0] blank);
      logic [15:0] res;
      res = data;
      for (int i = 0; i < 4; i++) begin
         if (blank[i]) res[i*4 +: 4] = BLANK_CODE;
      end
      return res;
   endfunction

endpackage

// File: rtl/scan_divider.sv
// Digit-slot timebase: divides clk into slots and slots into 4-slot frames.
module scan_divider #(
   parameter int unsigned SCAN_DIV = 10000
) (
   input  logic       clk,
   input  logic       rst,
   output logic [1:0] slot,
   output logic       slot_end_c,
   output logic       frame_end_c
);

   localparam int unsigned          DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [DIV_W-1:0] div;

   assign slot_end_c  = (div == DIV_LAST);
   assign frame_end_c = slot_end_c && (slot == 2'd3);

   // Divider and slot counter; slot wraps naturally from 3 to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         div  <= '0;
         slot <= 2'd0;
      end else if (slot_end_c) begin
         div  <= '0;
         slot <= slot + 2'd1;
      end else begin
         div  <= div + DIV_W'(1);
      end
   end

endmodule

// File: rtl/disp_scan_arbiter.sv
// Display owner arbiter (A default, B on request with bounded hold) and digit scanner.
module disp_scan_arbiter
   import disp_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 10000,
   parameter int unsigned MAX_B_FRAMES = 500,
   parameter int unsigned MIN_A_FRAMES = 250
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] a_data,
   input  logic        b_req,
   input  logic [15:0] b_data,
   input  logic [3:0]  b_blank,
   output logic        b_gnt,
   output logic [2:0]  AN,
   output logic [3:0]  D,
   output logic        frame_tick
);

   localparam logic [15:0] B_LAST = 16'(MAX_B_FRAMES - 1);
   localparam logic [15:0] A_LAST = 16'(MIN_A_FRAMES - 1);

   arb_state_t  state;
   logic [15:0] fcnt;
   logic [15:0] snap;
   logic [15:0] new_snap;
   logic [15:0] shown;
   logic [1:0]  slot;
   logic [1:0]  next_slot;
   logic        slot_end;
   logic        frame_end;
   logic        take_b;

   scan_divider #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan_divider (
      .clk         (clk),
      .rst         (rst),
      .slot        (slot),
      .slot_end_c  (slot_end),
      .frame_end_c (frame_end)
   );

   // Owner selected at the coming frame boundary.
   always_comb begin
      take_b = 1'b0;
      case (state)
         A_IDLE:     take_b = b_req;
         B_ACTIVE:   take_b = b_req && (fcnt != B_LAST);
         A_COOLDOWN: take_b = b_req && (fcnt == A_LAST);
         default:    take_b = 1'b0;
      endcase
   end

   assign new_snap  = take_b ? blank_mask(b_data, b_blank) : a_data;
   assign next_slot = slot + 2'd1;
   // The first slot of a frame must already show the snapshot taken at that edge.
   assign shown     = frame_end ? new_snap : snap;

   // Arbitration FSM, frame snapshot and registered display outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= A_IDLE;
         fcnt       <= 16'd0;
         snap       <= 16'hFFFF;
         b_gnt      <= 1'b0;
         AN         <= AN_D0;
         D          <= BLANK_CODE;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= frame_end;
         if (frame_end) begin
            snap  <= new_snap;
            b_gnt <= take_b;
            case (state)
               A_IDLE: begin
                  if (b_req) begin
                     state <= B_ACTIVE;
                     fcnt  <= 16'd0;
                  end
               end
               B_ACTIVE: begin
                  if (!b_req) begin
                     state <= A_IDLE;
                  end else if (fcnt == B_LAST) begin
                     state <= A_COOLDOWN;
                     fcnt  <= 16'd0;
                  end else begin
                     fcnt  <= fcnt + 16'd1;
                  end
               end
               A_COOLDOWN: begin
                  if (fcnt == A_LAST) begin
                     state <= b_req ? B_ACTIVE : A_IDLE;
                     fcnt  <= 16'd0;
                  end else begin
                     fcnt  <= fcnt + 16'd1;
                  end
               end
               default: begin
                  state <= A_IDLE;
                  fcnt  <= 16'd0;
               end
            endcase
         end
         if (slot_end) begin
            AN <= an_code(next_slot);
            D  <= digit_of(shown, next_slot);
         end
      end
   end

endmodule
